// File: rtl/ctrl_word_sequencer.sv
// Control-word sequencer: plays a writable table of datapath control words,
// free-running, looping or single-stepped, with a registered output word.
module ctrl_word_sequencer #(
    parameter int unsigned WORD_W = 23,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       step_mode,
    input  logic                       step,
    output logic [WORD_W-1:0]          ctrl_word,
    output logic                       ctrl_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   ptr,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    logic [WORD_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              err_q, err_d;
    logic [LW-1:0]     len_q, len_d;
    logic              loop_q, loop_d;
    logic              stepm_q, stepm_d;
    logic              busy_w;
    logic              last_w;

    assign busy_w = (state_q == RUN) || (state_q == HOLD);
    assign last_w = ({1'b0, ptr_q} == (len_q - LW'(1)));

    // Table has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_w) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        loop_d  = loop_q;
        stepm_d = stepm_q;
        err_d   = wr_en && busy_w;

        case (state_q)
            IDLE, DONE: begin
                if (start && !stop) begin
                    if ((len != '0) && (len <= LEN_MAX)) begin
                        len_d   = len;
                        loop_d  = loop_en;
                        stepm_d = step_mode;
                        ptr_d   = '0;
                        valid_d = 1'b1;
                        // A same-cycle write to entry 0 is forwarded so the new word plays.
                        word_d  = (wr_en && (wr_addr == '0)) ? wr_data : mem_q[AW'(0)];
                        state_d = step_mode ? HOLD : RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    word_d  = '0;
                    valid_d = 1'b0;
                    ptr_d   = '0;
                end else if ((state_q == RUN) || step) begin
                    if (last_w) begin
                        if (loop_q) begin
                            ptr_d  = '0;
                            word_d = mem_q[AW'(0)];
                        end else begin
                            state_d = DONE;
                            word_d  = '0;
                            valid_d = 1'b0;
                            ptr_d   = '0;
                        end
                    end else begin
                        ptr_d  = ptr_q + AW'(1);
                        word_d = mem_q[ptr_q + AW'(1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            stepm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            stepm_q <= stepm_d;
        end
    end

    assign ctrl_word  = word_q;
    assign ctrl_valid = valid_q;
    assign busy       = busy_w;
    assign done       = (state_q == DONE);
    assign ptr        = ptr_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Directed vector bench for ctrl_word_sequencer (default build plus DEPTH=4/WORD_W=8 build).
module tb_ctrl_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, start, stop, loop_en, step_mode, step;
    logic [3:0]  wr_addr;
    logic [22:0] wr_data;
    logic [4:0]  len;
    logic [22:0] ctrl_word;
    logic        ctrl_valid, busy, done, err;
    logic [3:0]  ptr;

    logic        wr_en4, start4, stop4, loop_en4, step_mode4, step4;
    logic [1:0]  wr_addr4;
    logic [7:0]  wr_data4;
    logic [2:0]  len4;
    logic [7:0]  ctrl_word4;
    logic        ctrl_valid4, busy4, done4, err4;
    logic [1:0]  ptr4;

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    ctrl_word_sequencer #(.WORD_W(23), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .loop_en(loop_en), .step_mode(step_mode),
        .step(step), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid), .busy(busy),
        .done(done), .ptr(ptr), .err(err)
    );

    ctrl_word_sequencer #(.WORD_W(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .len(len4), .start(start4), .stop(stop4), .loop_en(loop_en4), .step_mode(step_mode4),
        .step(step4), .ctrl_word(ctrl_word4), .ctrl_valid(ctrl_valid4), .busy(busy4),
        .done(done4), .ptr(ptr4), .err(err4)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [22:0] wd;
        logic        st, sp, stp;
        logic [4:0]  ln;
        logic        lp, sm;
        logic [22:0] ew;
        logic        ev, eb, ed;
        logic [3:0]  ep;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs: wr,wa,wd,st,sp,stp,ln,lp,sm ; expected after the edge: word,valid,busy,done,ptr,err
    task automatic add(input logic wr, input logic [3:0] wa, input logic [22:0] wd,
                       input logic st, input logic sp, input logic stp,
                       input logic [4:0] ln, input logic lp, input logic sm,
                       input logic [22:0] ew, input logic ev, input logic eb,
                       input logic ed, input logic [3:0] ep, input logic ee);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.st = st; v.sp = sp; v.stp = stp;
        v.ln = ln; v.lp = lp; v.sm = sm; v.ew = ew; v.ev = ev; v.eb = eb;
        v.ed = ed; v.ep = ep; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [22:0] ew, input logic ev, input logic eb,
                        input logic ed, input logic [3:0] ep, input logic ee);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, ew, ev, eb, ed, ep, ee);
    endtask

    task automatic expect_out(input string tag, input logic [22:0] ew, input logic ev,
                              input logic eb, input logic ed, input logic [3:0] ep);
        chk({tag, " word"}, 32'(ctrl_word), 32'(ew));
        chk({tag, " valid"}, 32'(ctrl_valid), 32'(ev));
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " done"}, 32'(done), 32'(ed));
        chk({tag, " ptr"}, 32'(ptr), 32'(ep));
    endtask

    initial begin
        rst = 1'b1;
        {wr_en, start, stop, loop_en, step_mode, step} = '0;
        wr_addr = '0; wr_data = '0; len = '0;
        {wr_en4, start4, stop4, loop_en4, step_mode4, step4} = '0;
        wr_addr4 = '0; wr_data4 = '0; len4 = '0;

        // table load
        add(1, 0, 23'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 23'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2, 23'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3, 23'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // single pass, len 4
        add(0, 0, 0, 1, 0, 0, 4, 0, 0, 23'h1, 1, 1, 0, 0, 0);
        idle(23'h2, 1, 1, 0, 1, 0);
        idle(23'h3, 1, 1, 0, 2, 0);
        idle(23'h4, 1, 1, 0, 3, 0);
        idle(0, 0, 0, 1, 0, 0);
        idle(0, 0, 0, 1, 0, 0);
        // looping pass, stop after 10 words
        add(0, 0, 0, 1, 0, 0, 4, 1, 0, 23'h1, 1, 1, 0, 0, 0);
        for (int k = 1; k < 10; k++) idle(23'((k % 4) + 1), 1, 1, 0, 4'(k % 4), 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // illegal lengths
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 17, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0, 0, 0, 0);
        // rejected write while running; start while busy ignored without err
        add(0, 0, 0, 1, 0, 0, 4, 0, 0, 23'h1, 1, 1, 0, 0, 0);
        add(1, 1, 23'h55, 0, 0, 0, 0, 0, 0, 23'h2, 1, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 2, 0, 0, 23'h3, 1, 1, 0, 2, 0);
        idle(23'h4, 1, 1, 0, 3, 0);
        idle(0, 0, 0, 1, 0, 0);
        // start+stop together: nothing starts; step outside HOLD ignored
        add(0, 0, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // step mode, len 3, steps at cycles 4 and 9, third step finishes
        add(0, 0, 0, 1, 0, 0, 3, 0, 1, 23'h1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) idle(23'h1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 23'h2, 1, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++) idle(23'h2, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 23'h3, 1, 1, 0, 2, 0);
        idle(23'h3, 1, 1, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // stop beats step in HOLD
        add(0, 0, 0, 1, 0, 0, 3, 0, 1, 23'h1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // write-first to entry 0 with start, then restore entry 0
        add(1, 0, 23'h7, 1, 0, 0, 1, 0, 0, 23'h7, 1, 1, 0, 0, 0);
        idle(0, 0, 0, 1, 0, 0);
        add(1, 0, 23'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0);
        chk("reset err", 32'(err), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            wr_en = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            start = tbl[i].st; stop = tbl[i].sp; step = tbl[i].stp;
            len = tbl[i].ln; loop_en = tbl[i].lp; step_mode = tbl[i].sm;
            tick();
            expect_out($sformatf("v%0d", i), tbl[i].ew, tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].ep);
            chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].ee));
        end
        {wr_en, start, stop, loop_en, step_mode, step} = '0;
        len = '0;

        // asynchronous reset in the middle of playback, then replay
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        expect_out("mid c1", 23'h1, 1, 1, 0, 0);
        tick();
        expect_out("mid c2", 23'h2, 1, 1, 0, 1);
        #2 rst = 1'b1;
        #1 expect_out("async rst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("replay %0d", k), 23'(k + 1), 1, 1, 0, 4'(k));
            tick();
        end
        expect_out("replay end", 0, 0, 0, 1, 0);

        // DEPTH=4 build: wrap 3->0 without a gap cycle
        for (int k = 0; k < 4; k++) begin
            wr_en4 = 1'b1; wr_addr4 = 2'(k); wr_data4 = 8'(8'hA0 + k);
            tick();
        end
        wr_en4 = 1'b0;
        start4 = 1'b1; len4 = 3'd4; loop_en4 = 1'b1;
        tick();
        start4 = 1'b0; loop_en4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("d4 word %0d", k), 32'(ctrl_word4), 32'(8'hA0 + (k % 4)));
            chk($sformatf("d4 ptr %0d", k), 32'(ptr4), 32'(k % 4));
            chk($sformatf("d4 valid %0d", k), 32'(ctrl_valid4), 1);
            tick();
        end
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        chk("d4 stop busy", 32'(busy4), 0);
        chk("d4 stop word", 32'(ctrl_word4), 0);
        start4 = 1'b1; len4 = 3'd5;
        tick();
        start4 = 1'b0;
        chk("d4 len5 err", 32'(err4), 1);
        chk("d4 len5 busy", 32'(busy4), 0);
        chk("d4 done", 32'(done4), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
